// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder cell.
module fulladder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Cout,
  output logic Sum
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one fulladder plus a carry register, LSB first,
// one bit per clock, result published with a one-cycle done pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int unsigned CW = $clog2(N + 1);

  state_t         state_q, state_d;
  logic [N-1:0]   opa_q, opa_d;
  logic [N-1:0]   opb_q, opb_d;
  logic [N-1:0]   res_q, res_d;
  logic [N-1:0]   sum_q, sum_d;
  logic [N-1:0]   msb_vec;
  logic           carry_q, carry_d;
  logic           cout_q, cout_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           fa_sum;
  logic           fa_cout;

  fulladder u_fa (
    .A    (opa_q[0]),
    .B    (opb_q[0]),
    .Cin  (carry_q),
    .Cout (fa_cout),
    .Sum  (fa_sum)
  );

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    // Sum bit placed at the MSB via a vector so N=1 needs no degenerate slice.
    msb_vec          = '0;
    msb_vec[N-1]     = fa_sum;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          carry_d = cin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        res_d   = (res_q >> 1) | msb_vec;
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        carry_d = fa_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          sum_d   = res_d;
          cout_d  = fa_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at N=8 and N=1.
module tb_serial_adder;

  logic       clk;
  logic       reset;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;

  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  int checks;
  int errors;
  int done_cnt8;
  int done_cnt1;

  logic [8:0] q8[$];
  logic [1:0] q1[$];
  time        done_t8[$];

  serial_adder #(.N(8)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder #(.N(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Result monitors: pop the expected value whenever a done pulse appears.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      done_cnt8++;
      done_t8.push_back($time);
      chk("n8_busy_with_done", {63'd0, busy8}, 64'd0);
      if (q8.size() == 0) begin
        chk("n8_unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [8:0] e;
        e = q8.pop_front();
        chk("n8_result", {55'd0, cout8, sum8}, {55'd0, e});
      end
    end
    if (done1 === 1'b1) begin
      done_cnt1++;
      chk("n1_busy_with_done", {63'd0, busy1}, 64'd0);
      if (q1.size() == 0) begin
        chk("n1_unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [1:0] e;
        e = q1.pop_front();
        chk("n1_result", {62'd0, cout1, sum1}, {62'd0, e});
      end
    end
  end

  // Returns #1 after the accepting edge.
  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit push);
    logic [8:0] e;
    @(posedge clk);
    #1;
    start8 = 1'b1;
    a8     = a;
    b8     = b;
    cin8   = c;
    e      = {1'b0, a} + {1'b0, b} + {8'd0, c};
    if (push) q8.push_back(e);
    @(posedge clk);
    #1;
    start8 = 1'b0;
    a8     = $urandom();
    b8     = $urandom();
    cin8   = $urandom_range(0, 1);
  endtask

  task automatic drive1(input logic a, input logic b, input logic c);
    @(posedge clk);
    #1;
    start1 = 1'b1;
    a1     = a;
    b1     = b;
    cin1   = c;
    q1.push_back({(a & b) | (c & (a ^ b)), a ^ b ^ c});
    @(posedge clk);
    #1;
    start1 = 1'b0;
    a1     = ~a;
    b1     = ~b;
    cin1   = ~c;
  endtask

  initial begin
    int base;
    checks = 0;
    errors = 0;
    done_cnt8 = 0;
    done_cnt1 = 0;
    reset  = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy8", {63'd0, busy8}, 64'd0);
    chk("rst_done8", {63'd0, done8}, 64'd0);
    chk("rst_sum8",  {55'd0, cout8, sum8}, 64'd0);
    chk("rst_busy1", {63'd0, busy1}, 64'd0);
    chk("rst_sum1",  {62'd0, cout1, sum1}, 64'd0);

    // 0x0F + 0x01: busy for exactly 8 cycles, then one done cycle.
    drive8(8'h0F, 8'h01, 1'b0, 1'b1);
    for (int unsigned k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("t1_busy_%0d", k), {63'd0, busy8}, 64'd1);
      chk($sformatf("t1_nodone_%0d", k), {63'd0, done8}, 64'd0);
    end
    @(negedge clk);
    chk("t1_done", {63'd0, done8}, 64'd1);
    repeat (3) @(negedge clk);
    chk("t1_done_low", {63'd0, done8}, 64'd0);
    chk("t1_sum_hold", {56'd0, sum8}, 64'h10);

    drive8(8'hFF, 8'h01, 1'b0, 1'b1);
    repeat (12) @(negedge clk);
    drive8(8'hFF, 8'hFF, 1'b1, 1'b1);
    repeat (12) @(negedge clk);

    // Start during SHIFT is ignored.
    base = done_cnt8;
    drive8(8'h05, 8'h03, 1'b0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (15) @(negedge clk);
    chk("t3_one_done", done_cnt8 - base, 64'd1);
    chk("t3_sum", {55'd0, cout8, sum8}, 64'h008);

    // Reset after the 4th SHIFT edge abandons the operation.
    base = done_cnt8;
    drive8(8'h7F, 8'h01, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t4_busy", {63'd0, busy8}, 64'd0);
    chk("t4_done", {63'd0, done8}, 64'd0);
    chk("t4_sum",  {55'd0, cout8, sum8}, 64'd0);
    repeat (10) @(negedge clk);
    chk("t4_no_done", done_cnt8 - base, 64'd0);
    drive8(8'h12, 8'h34, 1'b0, 1'b1);
    repeat (12) @(negedge clk);

    // N=1 truth table with one-edge latency.
    for (int unsigned v = 0; v < 8; v++) begin
      logic [2:0] bits;
      bits = v[2:0];
      drive1(bits[2], bits[1], bits[0]);
      @(negedge clk);
      chk($sformatf("n1_busy_%0d", v), {63'd0, busy1}, 64'd1);
      @(negedge clk);
      chk($sformatf("n1_done_%0d", v), {63'd0, done1}, 64'd1);
    end
    repeat (3) @(negedge clk);
    chk("n1_done_count", done_cnt1, 64'd8);

    // start held high for 30 edges: accepts every N+2 = 10 cycles.
    base = done_cnt8;
    done_t8.delete();
    @(posedge clk);
    #1;
    start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0;
    repeat (3) q8.push_back(9'h002);
    repeat (30) @(posedge clk);
    #1 start8 = 1'b0;
    repeat (12) @(negedge clk);
    chk("t6_done_count", done_cnt8 - base, 64'd3);
    if (done_t8.size() == 3) begin
      chk("t6_period_a", done_t8[1] - done_t8[0], 64'd100);
      chk("t6_period_b", done_t8[2] - done_t8[1], 64'd100);
    end

    chk("sb8_empty", q8.size(), 64'd0);
    chk("sb1_empty", q1.size(), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
